fifo_v4_thresh: RTL and testbench

//   Parametrised synchronous FIFO, next generation of the v3 FIFO used in axi_to_mem request/response paths.

---
 rtl/fifo_v4_thresh.sv | 139 +++++++++++++
 tb/tb_fifo_v4_thresh.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_v4_thresh.sv
// fifo_v4_thresh: parametrised synchronous FIFO with arbitrary depth, a full-range
// occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow
// flags. DEPTH == 0 degenerates to a combinational pass-through.
module fifo_v4_thresh #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ALM_FULL_TH  = 6,
    parameter int unsigned ALM_EMPTY_TH = 2,
    parameter int unsigned CNT_W        = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic                  err_clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  alm_full_o,
    output logic                  alm_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    // Pointer width covers indices 0..DEPTH-1; a single-entry FIFO still needs one bit.
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAST_IDX = (DEPTH > 0) ? DEPTH - 1 : 0;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(LAST_IDX)) ? '0 : ptr + 1'b1;
    endfunction

    if (DEPTH == 0) begin : g_passthru
        // No storage: the only state-free behaviour is a wire from data_i to data_o.
        logic unused_inputs;
        assign unused_inputs = ^{clk_i, rst_ni, flush_i, err_clr_i, testmode_i};

        assign data_o      = data_i;
        assign empty_o     = ~push_i;
        assign full_o      = ~pop_i;
        assign alm_full_o  = 1'b0;
        assign alm_empty_o = 1'b0;
        assign usage_o     = '0;
        assign ovf_o       = 1'b0;
        assign udf_o       = 1'b0;
    end else begin : g_fifo
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
        localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALM_FULL_TH);
        localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(ALM_EMPTY_TH);

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [CNT_W-1:0]      cnt_q;
        logic                  ovf_q;
        logic                  udf_q;
        logic                  full;
        logic                  empty_raw;
        logic                  empty;
        logic                  ft_bypass;
        logic                  push_ok;
        logic                  pop_ok;
        logic                  unused_testmode;

        assign unused_testmode = testmode_i;

        // An empty fall-through FIFO forwards data_i; with a simultaneous pop the word
        // is consumed on the spot, so neither the push nor the pop touches state.
        assign full      = (cnt_q == FULL_CNT);
        assign empty_raw = (cnt_q == '0);
        assign ft_bypass = FALL_THROUGH & empty_raw & push_i;
        assign empty     = empty_raw & ~ft_bypass;
        assign push_ok   = push_i & ~full & ~(ft_bypass & pop_i);
        assign pop_ok    = pop_i & ~empty_raw;

        assign data_o      = ft_bypass ? data_i : mem_q[rd_ptr_q];
        assign full_o      = full;
        assign empty_o     = empty;
        assign alm_full_o  = (cnt_q >= AF_CNT);
        assign alm_empty_o = (cnt_q <= AE_CNT);
        assign usage_o     = cnt_q;
        assign ovf_o       = ovf_q;
        assign udf_o       = udf_q;

        // Pointer and occupancy update; flush overrides any push/pop in the same cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_q <= next_ptr(wr_ptr_q);
                end
                if (pop_ok) begin
                    rd_ptr_q <= next_ptr(rd_ptr_q);
                end
                if (push_ok && !pop_ok) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop_ok && !push_ok) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

        // Sticky error flags: a new error in the clear cycle keeps the flag set.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end else begin
                ovf_q <= (push_i & full) | (ovf_q & ~err_clr_i);
                udf_q <= (pop_i & empty) | (udf_q & ~err_clr_i);
            end
        end

        // Storage is written only on an accepted push, keeping it clock-gate friendly.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push_ok && !flush_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_fifo_v4_thresh.sv
// Directed bench for fifo_v4_thresh: four instances cover DEPTH=5, DEPTH=8 with
// thresholds 6/2, a fall-through DEPTH=4 FIFO and the DEPTH=0 pass-through.
module tb_fifo_v4_thresh;

    logic clk = 1'b0;
    logic rst_n;
    logic tm;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Instance a: DEPTH=5, thresholds 4/1
    logic       a_push, a_pop, a_flush, a_clr;
    logic [7:0] a_data, a_q;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_use;

    // Instance b: DEPTH=8, thresholds 6/2
    logic       b_push, b_pop, b_flush, b_clr;
    logic [7:0] b_data, b_q;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_use;

    // Instance c: DEPTH=4, fall-through
    logic       c_push, c_pop, c_flush, c_clr;
    logic [7:0] c_data, c_q;
    logic       c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [2:0] c_use;

    // Instance z: DEPTH=0 pass-through
    logic       z_push, z_pop, z_flush, z_clr;
    logic [7:0] z_data, z_q;
    logic       z_full, z_empty, z_af, z_ae, z_ovf, z_udf;
    logic [0:0] z_use;

    fifo_v4_thresh #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5), .ALM_FULL_TH(4), .ALM_EMPTY_TH(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(tm), .err_clr_i(a_clr),
        .data_i(a_data), .push_i(a_push), .pop_i(a_pop), .data_o(a_q), .full_o(a_full),
        .empty_o(a_empty), .alm_full_o(a_af), .alm_empty_o(a_ae), .usage_o(a_use),
        .ovf_o(a_ovf), .udf_o(a_udf));

    fifo_v4_thresh #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8), .ALM_FULL_TH(6), .ALM_EMPTY_TH(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(tm), .err_clr_i(b_clr),
        .data_i(b_data), .push_i(b_push), .pop_i(b_pop), .data_o(b_q), .full_o(b_full),
        .empty_o(b_empty), .alm_full_o(b_af), .alm_empty_o(b_ae), .usage_o(b_use),
        .ovf_o(b_ovf), .udf_o(b_udf));

    fifo_v4_thresh #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4), .ALM_FULL_TH(3), .ALM_EMPTY_TH(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .testmode_i(tm), .err_clr_i(c_clr),
        .data_i(c_data), .push_i(c_push), .pop_i(c_pop), .data_o(c_q), .full_o(c_full),
        .empty_o(c_empty), .alm_full_o(c_af), .alm_empty_o(c_ae), .usage_o(c_use),
        .ovf_o(c_ovf), .udf_o(c_udf));

    fifo_v4_thresh #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0), .ALM_FULL_TH(1), .ALM_EMPTY_TH(0)) u_z (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(z_flush), .testmode_i(tm), .err_clr_i(z_clr),
        .data_i(z_data), .push_i(z_push), .pop_i(z_pop), .data_o(z_q), .full_o(z_full),
        .empty_o(z_empty), .alm_full_o(z_af), .alm_empty_o(z_ae), .usage_o(z_use),
        .ovf_o(z_ovf), .udf_o(z_udf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        tm = 1'b0;
        rst_n = 1'b0;
        {a_push, a_pop, a_flush, a_clr} = '0; a_data = '0;
        {b_push, b_pop, b_flush, b_clr} = '0; b_data = '0;
        {c_push, c_pop, c_flush, c_clr} = '0; c_data = '0;
        {z_push, z_pop, z_flush, z_clr} = '0; z_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_b_use", b_use, 0);
        chk("rst_b_full", b_full, 0);
        chk("rst_b_empty", b_empty, 1);
        chk("rst_b_af", b_af, 0);
        chk("rst_b_ae", b_ae, 1);
        chk("rst_b_ovf", b_ovf, 0);
        chk("rst_b_udf", b_udf, 0);
        chk("rst_b_q", b_q, 0);
        chk("rst_a_empty", a_empty, 1);
        chk("rst_c_full", c_full, 0);
        chk("rst_c_af", c_af, 0);
        chk("rst_c_ae", c_ae, 1);
        rst_n = 1'b1;
        tick();

        // DEPTH=0 pass-through
        z_push = 1'b1; z_data = 8'h3C; #1;
        chk("z_q", z_q, 8'h3C);
        chk("z_empty_push", z_empty, 0);
        chk("z_full_nopop", z_full, 1);
        chk("z_use", z_use, 0);
        z_push = 1'b0; z_pop = 1'b1; #1;
        chk("z_empty_nopush", z_empty, 1);
        chk("z_full_pop", z_full, 0);
        tick();
        z_pop = 1'b0; #1;
        chk("z_ovf", z_ovf, 0);
        chk("z_udf", z_udf, 0);
        chk("z_af", z_af, 0);
        chk("z_ae", z_ae, 0);

        // DEPTH=5: 7 pushes, 5 accepted, overflow flagged
        for (int i = 1; i <= 7; i++) begin
            a_push = 1'b1; a_data = 8'(i);
            tick();
            if (i == 1) begin
                chk("a_first_empty", a_empty, 0);
                chk("a_first_q", a_q, 1);
            end
        end
        a_push = 1'b0; #1;
        chk("a_full", a_full, 1);
        chk("a_use5", a_use, 5);
        chk("a_ovf", a_ovf, 1);
        chk("a_udf0", a_udf, 0);
        chk("a_af", a_af, 1);
        for (int i = 1; i <= 5; i++) begin
            a_pop = 1'b1; #1;
            chk("a_pop_q", a_q, i);
            tick();
        end
        a_pop = 1'b0; #1;
        chk("a_drained_empty", a_empty, 1);
        chk("a_drained_use", a_use, 0);
        chk("a_drained_ae", a_ae, 1);
        chk("a_drained_udf", a_udf, 0);

        // DEPTH=5: 12 push+pop pairs at count 2, pointers wrap
        a_push = 1'b1; a_data = 8'h10; tick();
        a_data = 8'h11; tick();
        a_push = 1'b0;
        for (int k = 0; k < 12; k++) begin
            a_push = 1'b1; a_pop = 1'b1; a_data = 8'(8'h12 + k); #1;
            chk("a_pair_q", a_q, 8'h10 + k);
            tick();
            chk("a_pair_use", a_use, 2);
        end
        a_push = 1'b0; a_pop = 1'b0;

        // Fall-through, empty, push+pop together
        c_push = 1'b1; c_pop = 1'b1; c_data = 8'hA5; #1;
        chk("c_ft_q", c_q, 8'hA5);
        chk("c_ft_empty", c_empty, 0);
        tick();
        c_push = 1'b0; c_pop = 1'b0; #1;
        chk("c_ft_use", c_use, 0);
        chk("c_ft_empty_after", c_empty, 1);
        chk("c_ft_udf", c_udf, 0);
        chk("c_ft_ovf", c_ovf, 0);

        // Non-fall-through, empty, push+pop together
        b_push = 1'b1; b_pop = 1'b1; b_data = 8'hA5; #1;
        chk("b_nft_empty", b_empty, 1);
        tick();
        b_push = 1'b0; b_pop = 1'b0; #1;
        chk("b_nft_use", b_use, 1);
        chk("b_nft_udf", b_udf, 1);
        chk("b_nft_q", b_q, 8'hA5);
        chk("b_nft_empty_after", b_empty, 0);
        b_clr = 1'b1; tick();
        b_clr = 1'b0; #1;
        chk("b_udf_clr", b_udf, 0);
        b_pop = 1'b1; tick();
        b_pop = 1'b0; #1;
        chk("b_use_back0", b_use, 0);

        // DEPTH=8 fill with threshold flags
        for (int n = 0; n <= 8; n++) begin
            chk("b_fill_use", b_use, n);
            chk("b_fill_ae", b_ae, (n <= 2));
            chk("b_fill_af", b_af, (n >= 6));
            chk("b_fill_full", b_full, (n == 8));
            if (n < 8) begin
                b_push = 1'b1; b_data = 8'(8'h40 + n);
                tick();
                b_push = 1'b0; #1;
            end
        end

        // Full with push+pop: pop wins, push dropped, overflow set
        b_push = 1'b1; b_pop = 1'b1; b_data = 8'hEE; #1;
        chk("b_fullpp_q", b_q, 8'h40);
        tick();
        b_push = 1'b0; b_pop = 1'b0; #1;
        chk("b_fullpp_use", b_use, 7);
        chk("b_fullpp_ovf", b_ovf, 1);
        chk("b_fullpp_full", b_full, 0);
        b_push = 1'b1; b_data = 8'h48; tick();
        b_push = 1'b0; #1;
        chk("b_refull", b_full, 1);
        b_push = 1'b1; b_clr = 1'b1; b_data = 8'h99; tick();
        b_push = 1'b0; b_clr = 1'b0; #1;
        chk("b_set_wins", b_ovf, 1);
        chk("b_set_wins_use", b_use, 8);
        b_clr = 1'b1; tick();
        b_clr = 1'b0; #1;
        chk("b_ovf_clr", b_ovf, 0);

        // Drain, flags mirror the fill
        for (int n = 8; n >= 1; n--) begin
            chk("b_drain_use", b_use, n);
            chk("b_drain_ae", b_ae, (n <= 2));
            chk("b_drain_af", b_af, (n >= 6));
            chk("b_drain_q", b_q, 8'h41 + (8 - n));
            b_pop = 1'b1; tick();
            b_pop = 1'b0; #1;
        end
        chk("b_drain_use0", b_use, 0);
        chk("b_drain_ae0", b_ae, 1);
        chk("b_drain_af0", b_af, 0);
        chk("b_drain_empty", b_empty, 1);

        // Flush at count 3 with a push in the same cycle
        for (int i = 0; i < 3; i++) begin
            b_push = 1'b1; b_data = 8'(8'h51 + i); tick();
        end
        b_push = 1'b0; #1;
        chk("b_pre_flush_use", b_use, 3);
        b_push = 1'b1; b_flush = 1'b1; b_data = 8'h54; tick();
        b_push = 1'b0; b_flush = 1'b0; #1;
        chk("b_flush_use", b_use, 0);
        chk("b_flush_empty", b_empty, 1);
        chk("b_flush_ovf", b_ovf, 0);
        b_pop = 1'b1; tick();
        b_pop = 1'b0; #1;
        chk("b_udf_set", b_udf, 1);

        // Asynchronous reset in the middle of a burst
        b_push = 1'b1; b_data = 8'h61; tick();
        b_data = 8'h62; tick();
        chk("b_burst_q", b_q, 8'h61);
        #2;
        rst_n = 1'b0; #1;
        chk("arst_use", b_use, 0);
        chk("arst_full", b_full, 0);
        chk("arst_empty", b_empty, 1);
        chk("arst_af", b_af, 0);
        chk("arst_ae", b_ae, 1);
        chk("arst_ovf", b_ovf, 0);
        chk("arst_udf", b_udf, 0);
        chk("arst_q", b_q, 0);
        b_push = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
